id_branch_predict_ctrl: RTL and testbench

ID-stage branch/jump control with a parametrised direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- IF side: looks up the fetch PC and supplies a predicted next PC.
- ID side: decodes the instruction, drives compare/NPC/extend/RS-mux selects, resolves the actual outcome from cmp_out, trains the table, and raises redirect/flush only on a misprediction.
- Replaces flush-on-every-taken control; the pipeline has no delay slot.

---
 rtl/id_branch_predict_ctrl_pkg.sv | 47 ++++
 rtl/id_branch_predict_ctrl_if.sv | 41 ++++
 rtl/id_branch_predict_ctrl_btb_table.sv | 63 ++++++
 rtl/id_branch_predict_ctrl.sv | 155 +++++++++++++++
 tb/tb_id_branch_predict_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_branch_predict_ctrl_pkg.sv
// Shared opcode, funct and select encodings for the ID-stage branch control.
// Also holds the control-transfer class type and the 2-bit counter update rule.
package id_branch_predict_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [2:0] CMPOP_BEQ  = 3'b000;
    localparam logic [2:0] CMPOP_BNE  = 3'b001;
    localparam logic [2:0] CMPOP_BLEZ = 3'b010;
    localparam logic [2:0] CMPOP_BGTZ = 3'b011;
    localparam logic [2:0] CMPOP_BLTZ = 3'b100;
    localparam logic [2:0] CMPOP_BGEZ = 3'b101;
    localparam logic [2:0] CMPOP_NONE = 3'b111;

    localparam logic NPCOP_B = 1'b0;
    localparam logic NPCOP_J = 1'b1;

    typedef enum logic [1:0] {
        CTI_NONE = 2'd0,
        CTI_BR   = 2'd1,
        CTI_J    = 2'd2,
        CTI_JR   = 2'd3
    } cti_e;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/id_branch_predict_ctrl_if.sv
// IF-lookup, ID-resolve and statistics signals of the branch control block.
interface id_branch_predict_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] if_pc;
    logic              if_pred_taken;
    logic [ADDR_W-1:0] if_pred_pc;
    logic              id_valid;
    logic              id_stall;
    logic [31:0]       id_ir;
    logic [ADDR_W-1:0] id_pc;
    logic              id_pred_taken;
    logic [ADDR_W-1:0] id_pred_pc;
    logic [ADDR_W-1:0] id_npc;
    logic [ADDR_W-1:0] id_rs;
    logic              cmp_out;
    logic [2:0]        cmp_op;
    logic              npc_op;
    logic              ext_op;
    logic              rs_e_sel;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  mis_count;

    modport slave (
        input  if_pc, id_valid, id_stall, id_ir, id_pc, id_pred_taken, id_pred_pc,
               id_npc, id_rs, cmp_out,
        output if_pred_taken, if_pred_pc, cmp_op, npc_op, ext_op, rs_e_sel,
               redirect, redirect_pc, flush, br_count, mis_count
    );

    modport master (
        output if_pc, id_valid, id_stall, id_ir, id_pc, id_pred_taken, id_pred_pc,
               id_npc, id_rs, cmp_out,
        input  if_pred_taken, if_pred_pc, cmp_op, npc_op, ext_op, rs_e_sel,
               redirect, redirect_pc, flush, br_count, mis_count
    );
endinterface

// File: rtl/id_branch_predict_ctrl_btb_table.sv
// Direct-mapped BTB storage: combinational reads for the IF lookup and the ID
// training path, one registered write, valid/counter fields cleared by reset.
module id_branch_predict_ctrl_btb_table #(
    parameter int BTB_DEPTH = 64,
    parameter int TAG_W     = 24,
    parameter int TGT_W     = 30,
    parameter int IDX_W     = $clog2(BTB_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] ra_idx,
    output logic             ra_valid,
    output logic [TAG_W-1:0] ra_tag,
    output logic [TGT_W-1:0] ra_tgt,
    output logic [1:0]       ra_cnt,
    input  logic [IDX_W-1:0] rb_idx,
    output logic             rb_valid,
    output logic [TAG_W-1:0] rb_tag,
    output logic [TGT_W-1:0] rb_tgt,
    output logic [1:0]       rb_cnt,
    input  logic             we,
    input  logic [IDX_W-1:0] wa_idx,
    input  logic             w_valid,
    input  logic [TAG_W-1:0] w_tag,
    input  logic [TGT_W-1:0] w_tgt,
    input  logic [1:0]       w_cnt
);
    logic             valid_q [BTB_DEPTH];
    logic [1:0]       cnt_q   [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
    logic [TGT_W-1:0] tgt_q   [BTB_DEPTH];

    // Reads see only state committed on earlier edges (read-before-write).
    assign ra_valid = valid_q[ra_idx];
    assign ra_tag   = tag_q[ra_idx];
    assign ra_tgt   = tgt_q[ra_idx];
    assign ra_cnt   = cnt_q[ra_idx];
    assign rb_valid = valid_q[rb_idx];
    assign rb_tag   = tag_q[rb_idx];
    assign rb_tgt   = tgt_q[rb_idx];
    assign rb_cnt   = cnt_q[rb_idx];

    generate
        for (genvar gi = 0; gi < BTB_DEPTH; gi++) begin : g_state
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q[gi] <= 1'b0;
                    cnt_q[gi]   <= 2'b01;
                end else if (we && (wa_idx == IDX_W'(gi))) begin
                    valid_q[gi] <= w_valid;
                    cnt_q[gi]   <= w_cnt;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wa_idx] <= w_tag;
            tgt_q[wa_idx] <= w_tgt;
        end
    end
endmodule

// File: rtl/id_branch_predict_ctrl.sv
// ID-stage branch/jump control: decode selects, BTB prediction for IF,
// outcome resolution, mispredict redirect, table training and statistics.
module id_branch_predict_ctrl
    import id_branch_predict_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 64,
    parameter int IDX_W     = $clog2(BTB_DEPTH),
    parameter int TAG_W     = ADDR_W - IDX_W - 2,
    parameter int CNT_W     = 32
) (
    input  logic clk,
    input  logic reset,
    id_branch_predict_ctrl_if.slave bus
);
    localparam int TGT_W = ADDR_W - 2;

    logic [5:0]        op, funct;
    logic [4:0]        rt;
    cti_e              cls;
    logic              active, actual_taken, mispredict;
    logic [ADDR_W-1:0] actual_pc, id_pc_plus4;
    logic              ra_valid, rb_valid, if_hit, id_hit;
    logic [TAG_W-1:0]  ra_tag, rb_tag;
    logic [TGT_W-1:0]  ra_tgt, rb_tgt;
    logic [1:0]        ra_cnt, rb_cnt;
    logic              we, w_valid;
    logic [TGT_W-1:0]  w_tgt;
    logic [1:0]        w_cnt;
    logic [CNT_W-1:0]  br_count_q, br_count_d, mis_count_q, mis_count_d;
    logic              unused_bits;

    assign op    = bus.id_ir[31:26];
    assign rt    = bus.id_ir[20:16];
    assign funct = bus.id_ir[5:0];
    assign unused_bits = ^{bus.id_ir[25:21], bus.id_ir[15:6], actual_pc[1:0]};

    always_comb begin
        bus.cmp_op   = CMPOP_NONE;
        bus.npc_op   = NPCOP_B;
        bus.rs_e_sel = 1'b0;
        cls          = CTI_NONE;
        case (op)
            OP_BEQ:    bus.cmp_op = CMPOP_BEQ;
            OP_BNE:    bus.cmp_op = CMPOP_BNE;
            OP_BLEZ:   bus.cmp_op = CMPOP_BLEZ;
            OP_BGTZ:   bus.cmp_op = CMPOP_BGTZ;
            OP_REGIMM: begin
                if (rt == 5'd0)      bus.cmp_op = CMPOP_BLTZ;
                else if (rt == 5'd1) bus.cmp_op = CMPOP_BGEZ;
            end
            OP_J, OP_JAL: begin
                bus.npc_op = NPCOP_J;
                cls        = CTI_J;
            end
            OP_RTYPE: begin
                if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) bus.rs_e_sel = 1'b1;
                if (funct == FN_JR || funct == FN_JALR)                   cls = CTI_JR;
            end
            default: ;
        endcase
        if (bus.cmp_op != CMPOP_NONE) cls = CTI_BR;
    end

    // Sign-extend class: branches, ADDI..SLTIU, loads and stores.
    assign bus.ext_op = (op == OP_REGIMM) || (op >= OP_BEQ && op <= OP_SLTIU) || (op[5:4] == 2'b10);

    id_branch_predict_ctrl_btb_table #(
        .BTB_DEPTH(BTB_DEPTH), .TAG_W(TAG_W), .TGT_W(TGT_W), .IDX_W(IDX_W)
    ) u_btb (
        .clk(clk), .reset(reset),
        .ra_idx(bus.if_pc[IDX_W+1:2]), .ra_valid(ra_valid), .ra_tag(ra_tag),
        .ra_tgt(ra_tgt), .ra_cnt(ra_cnt),
        .rb_idx(bus.id_pc[IDX_W+1:2]), .rb_valid(rb_valid), .rb_tag(rb_tag),
        .rb_tgt(rb_tgt), .rb_cnt(rb_cnt),
        .we(we), .wa_idx(bus.id_pc[IDX_W+1:2]), .w_valid(w_valid),
        .w_tag(bus.id_pc[ADDR_W-1:IDX_W+2]), .w_tgt(w_tgt), .w_cnt(w_cnt)
    );

    assign if_hit            = ra_valid && (ra_tag == bus.if_pc[ADDR_W-1:IDX_W+2]);
    assign id_hit            = rb_valid && (rb_tag == bus.id_pc[ADDR_W-1:IDX_W+2]);
    assign bus.if_pred_taken = !reset && if_hit && ra_cnt[1];
    assign bus.if_pred_pc    = bus.if_pred_taken ? {ra_tgt, 2'b00} : bus.if_pc + ADDR_W'(4);

    assign active      = bus.id_valid && !bus.id_stall && !reset;
    assign id_pc_plus4 = bus.id_pc + ADDR_W'(4);

    always_comb begin
        actual_taken = 1'b0;
        actual_pc    = id_pc_plus4;
        case (cls)
            CTI_BR: begin
                actual_taken = bus.cmp_out;
                actual_pc    = bus.cmp_out ? bus.id_npc : id_pc_plus4;
            end
            CTI_J: begin
                actual_taken = 1'b1;
                actual_pc    = bus.id_npc;
            end
            CTI_JR: begin
                actual_taken = 1'b1;
                actual_pc    = bus.id_rs;
            end
            default: ;
        endcase
    end

    assign mispredict = active && ((bus.id_pred_taken != actual_taken) ||
                                   (actual_taken && bus.id_pred_pc != actual_pc));
    assign bus.redirect    = mispredict;
    assign bus.flush       = mispredict;
    assign bus.redirect_pc = actual_pc;

    // JR/JALR targets are register-dependent and are never cached.
    always_comb begin
        we      = 1'b0;
        w_valid = 1'b1;
        w_tgt   = rb_tgt;
        w_cnt   = rb_cnt;
        if (active && (cls == CTI_BR || cls == CTI_J)) begin
            if (id_hit) begin
                we    = 1'b1;
                w_cnt = cnt_update(rb_cnt, actual_taken);
                if (actual_taken) w_tgt = actual_pc[ADDR_W-1:2];
            end else if (actual_taken) begin
                we    = 1'b1;
                w_tgt = actual_pc[ADDR_W-1:2];
                w_cnt = 2'b10;
            end
        end else if (active && cls == CTI_NONE && bus.id_pred_taken && id_hit) begin
            we      = 1'b1;
            w_valid = 1'b0;
        end
    end

    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (active && cls != CTI_NONE && br_count_q != '1) br_count_d = br_count_q + 1'b1;
        if (mispredict && mis_count_q != '1)               mis_count_d = mis_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    assign bus.br_count  = br_count_q;
    assign bus.mis_count = mis_count_q;
endmodule

// File: tb/tb_id_branch_predict_ctrl.sv
// Bench for id_branch_predict_ctrl: decode table, directed BTB sequences and
// randomized traffic against a behavioural predictor model.
module tb_id_branch_predict_ctrl;
    import id_branch_predict_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_branch_predict_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    id_branch_predict_ctrl #(.ADDR_W(ADDR_W), .BTB_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;

    bit          m_v   [DEPTH];
    logic [31:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_cnt [DEPTH];
    int          m_br, m_mis;

    logic        o_pt, o_redir;
    logic [31:0] o_ppc, o_rpc;

    typedef struct {
        logic [31:0] ir;
        logic [2:0]  cmp;
        logic        npc, ext, rse;
    } dec_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_i(input int op, input int rt, input int imm);
        return {6'(op), 5'd1, 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] mk_r(input int fn);
        return {6'd0, 5'd3, 5'd4, 5'd5, 5'd2, 6'(fn)};
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction
    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 8));
    endfunction

    // 0 = other, 1 = conditional branch, 2 = J/JAL, 3 = JR/JALR
    function automatic int kind(input logic [31:0] ir);
        int op = int'(ir[31:26]);
        if (op >= 4 && op <= 7) return 1;
        if (op == 1 && ir[20:16] <= 5'd1) return 1;
        if (op == 2 || op == 3) return 2;
        if (op == 0 && (ir[5:0] == 6'd8 || ir[5:0] == 6'd9)) return 3;
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_br = 0; m_mis = 0;
    endtask

    task automatic m_predict(input logic [31:0] pc, output bit pt, output logic [31:0] ppc);
        pt  = m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
        ppc = pt ? m_tgt[m_idx(pc)] : pc + 4;
    endtask

    task automatic step(input bit rst, input bit v, input bit st, input logic [31:0] ir,
                        input logic [31:0] pc, input bit pt, input logic [31:0] ppc,
                        input logic [31:0] npc, input logic [31:0] rs, input bit cmp,
                        input logic [31:0] ipc, input string name);
        bit          e_pt, act, at, mis;
        logic [31:0] e_ppc, apc;
        int          k, ix;
        reset = rst;
        bus.id_valid = v; bus.id_stall = st; bus.id_ir = ir; bus.id_pc = pc;
        bus.id_pred_taken = pt; bus.id_pred_pc = ppc; bus.id_npc = npc;
        bus.id_rs = rs; bus.cmp_out = cmp; bus.if_pc = ipc;
        #2;
        m_predict(ipc, e_pt, e_ppc);
        if (rst) begin e_pt = 0; e_ppc = ipc + 4; end
        act = v && !st && !rst;
        k   = kind(ir);
        at  = (k == 1) ? cmp : (k >= 2);
        apc = (k == 2) ? npc : (k == 3) ? rs : (k == 1 && cmp) ? npc : pc + 4;
        mis = act && (pt != at || (at && ppc != apc));
        o_pt = bus.if_pred_taken; o_ppc = bus.if_pred_pc;
        o_redir = bus.redirect; o_rpc = bus.redirect_pc;
        chk({name, " if_pred_taken"}, 32'(bus.if_pred_taken), 32'(e_pt));
        chk({name, " if_pred_pc"}, bus.if_pred_pc, e_ppc);
        chk({name, " redirect"}, 32'(bus.redirect), 32'(mis));
        chk({name, " flush"}, 32'(bus.flush), 32'(mis));
        if (mis) chk({name, " redirect_pc"}, bus.redirect_pc, apc);
        chk({name, " br_count"}, 32'(bus.br_count), 32'(m_br));
        chk({name, " mis_count"}, 32'(bus.mis_count), 32'(m_mis));
        $display("txn %s rst=%0d v=%0d st=%0d pc=%h kind=%0d mis=%0d ifpc=%h pred=%0d/%h",
                 name, rst, v, st, pc, k, mis, ipc, e_pt, e_ppc);
        @(posedge clk);
        #1;
        if (rst) begin
            m_reset();
        end else if (act) begin
            ix = m_idx(pc);
            if (k == 1 || k == 2) begin
                if (m_hit(pc)) begin
                    m_cnt[ix] = at ? ((m_cnt[ix] < 3) ? m_cnt[ix] + 1 : 3)
                                   : ((m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0);
                    if (at) m_tgt[ix] = apc;
                end else if (at) begin
                    m_v[ix] = 1; m_tag[ix] = pc >> 8; m_tgt[ix] = apc; m_cnt[ix] = 2;
                end
            end else if (k == 0 && pt && m_hit(pc)) begin
                m_v[ix] = 0;
            end
            if (k != 0 && m_br < CMAX) m_br++;
            if (mis && m_mis < CMAX) m_mis++;
        end
    endtask

    task automatic idle(input logic [31:0] ipc, input string name);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h4, 32'h0, 32'h0, 0, ipc, name);
    endtask

    logic [31:0] BEQ, JR, ADDI;
    localparam logic [31:0] B = 32'h0040_0010;

    initial begin
        dec_vec_t dv [15];
        bit          rpt;
        logic [31:0] rppc, rpc, ripc, rnpc, rir;
        logic [31:0] kinds [12];

        dv[0]  = '{mk_i(6'h04, 0, 3), CMPOP_BEQ,  1'b0, 1'b1, 1'b0};
        dv[1]  = '{mk_i(6'h05, 0, 3), CMPOP_BNE,  1'b0, 1'b1, 1'b0};
        dv[2]  = '{mk_i(6'h06, 0, 3), CMPOP_BLEZ, 1'b0, 1'b1, 1'b0};
        dv[3]  = '{mk_i(6'h07, 0, 3), CMPOP_BGTZ, 1'b0, 1'b1, 1'b0};
        dv[4]  = '{mk_i(6'h01, 0, 3), 3'b100,     1'b0, 1'b1, 1'b0};
        dv[5]  = '{mk_i(6'h01, 1, 3), 3'b101,     1'b0, 1'b1, 1'b0};
        dv[6]  = '{mk_i(6'h01, 2, 3), 3'b111,     1'b0, 1'b1, 1'b0};
        dv[7]  = '{mk_i(6'h02, 0, 3), 3'b111,     1'b1, 1'b0, 1'b0};
        dv[8]  = '{mk_i(6'h03, 0, 3), 3'b111,     1'b1, 1'b0, 1'b0};
        dv[9]  = '{mk_i(6'h0d, 0, 3), 3'b111,     1'b0, 1'b0, 1'b0};
        dv[10] = '{mk_i(6'h23, 0, 3), 3'b111,     1'b0, 1'b1, 1'b0};
        dv[11] = '{mk_r(6'h00),       3'b111,     1'b0, 1'b0, 1'b1};
        dv[12] = '{mk_r(6'h03),       3'b111,     1'b0, 1'b0, 1'b1};
        dv[13] = '{mk_r(6'h21),       3'b111,     1'b0, 1'b0, 1'b0};
        dv[14] = '{mk_r(6'h08),       3'b111,     1'b0, 1'b0, 1'b0};

        BEQ  = mk_i(6'h04, 2, 11);
        JR   = mk_r(6'h08);
        ADDI = mk_i(6'h08, 2, 5);
        m_reset();

        // Reset, then cold lookup
        step(1, 0, 0, 32'h0, 32'h0, 0, 32'h4, 32'h0, 32'h0, 0, 32'h0040_0000, "reset0");
        step(1, 0, 0, 32'h0, 32'h0, 0, 32'h4, 32'h0, 32'h0, 0, 32'h0040_0000, "reset1");
        idle(32'h0040_0000, "cold");
        chk("cold pred_taken", 32'(o_pt), 32'd0);
        chk("cold pred_pc", o_ppc, 32'h0040_0004);

        for (int i = 0; i < 15; i++) begin
            bus.id_valid = 0; bus.id_ir = dv[i].ir;
            #2;
            chk($sformatf("dec%0d cmp_op", i), 32'(bus.cmp_op), 32'(dv[i].cmp));
            chk($sformatf("dec%0d npc_op", i), 32'(bus.npc_op), 32'(dv[i].npc));
            chk($sformatf("dec%0d ext_op", i), 32'(bus.ext_op), 32'(dv[i].ext));
            chk($sformatf("dec%0d rs_e_sel", i), 32'(bus.rs_e_sel), 32'(dv[i].rse));
            $display("txn decode%0d ir=%h", i, dv[i].ir);
        end

        // Cold BEQ taken: mispredict then allocate
        step(0, 1, 0, BEQ, B, 0, B + 4, 32'h0040_0040, 0, 1, 32'h0040_0000, "beq_cold");
        chk("beq_cold redirect", 32'(o_redir), 32'd1);
        chk("beq_cold redirect_pc", o_rpc, 32'h0040_0040);
        idle(B, "look_alloc");
        chk("alloc pred_taken", 32'(o_pt), 32'd1);
        chk("alloc pred_pc", o_ppc, 32'h0040_0040);
        step(0, 1, 0, BEQ, B, 1, 32'h0040_0040, 32'h0040_0040, 0, 1, B, "beq_hit_t");
        chk("beq_hit_t redirect", 32'(o_redir), 32'd0);
        m_predict(B, rpt, rppc);
        step(0, 1, 0, BEQ, B, rpt, rppc, 32'h0040_0040, 0, 0, B, "beq_nt1");
        chk("beq_nt1 redirect_pc", o_rpc, 32'h0040_0014);
        m_predict(B, rpt, rppc);
        step(0, 1, 0, BEQ, B, rpt, rppc, 32'h0040_0040, 0, 0, B, "beq_nt2");
        idle(B, "look_weak");
        chk("weak pred_taken", 32'(o_pt), 32'd0);

        // JR never allocates
        step(0, 1, 0, JR, 32'h0040_0100, 0, 32'h0040_0104, 0, 32'h0040_0800, 0, B, "jr");
        chk("jr redirect_pc", o_rpc, 32'h0040_0800);
        idle(32'h0040_0100, "look_jr");
        chk("jr no alloc", 32'(o_pt), 32'd0);

        // Stall suppresses resolution until released
        step(0, 1, 1, BEQ, 32'h0040_0020, 0, 32'h0040_0024, 32'h0040_0080, 0, 1, B, "stall");
        chk("stall redirect", 32'(o_redir), 32'd0);
        step(0, 1, 0, BEQ, 32'h0040_0020, 0, 32'h0040_0024, 32'h0040_0080, 0, 1, B, "unstall");
        chk("unstall redirect", 32'(o_redir), 32'd1);

        // Aliasing on index 4
        step(0, 1, 0, BEQ, 32'h0040_0110, 0, 32'h0040_0114, 32'h0040_0200, 0, 1, B, "alias");
        idle(B, "look_old");
        chk("alias old miss", 32'(o_pt), 32'd0);
        idle(32'h0040_0110, "look_new");
        chk("alias new pred_pc", o_ppc, 32'h0040_0200);

        // Non-CTI predicted taken invalidates its entry
        step(0, 1, 0, ADDI, 32'h0040_0110, 1, 32'h0040_0200, 0, 0, 0, 32'h0040_0110, "noncti");
        chk("noncti redirect_pc", o_rpc, 32'h0040_0114);
        idle(32'h0040_0110, "look_inval");
        chk("noncti invalidated", 32'(o_pt), 32'd0);

        // Reset during an active mispredicting branch
        step(1, 1, 0, BEQ, 32'h0040_0030, 0, 32'h0040_0034, 32'h0040_0090, 0, 1,
             32'h0040_0030, "mid_reset");
        chk("mid_reset redirect", 32'(o_redir), 32'd0);
        idle(32'h0040_0030, "post_reset");
        chk("post_reset br_count", 32'(bus.br_count), 32'd0);

        // Randomized traffic, long enough to saturate the 8-bit counters
        kinds = '{mk_i(6'h04, 0, 1), mk_i(6'h05, 0, 1), mk_i(6'h06, 0, 1), mk_i(6'h07, 0, 1),
                  mk_i(6'h01, 0, 1), mk_i(6'h01, 1, 1), mk_i(6'h02, 0, 1), mk_i(6'h03, 0, 1),
                  mk_r(6'h08), mk_r(6'h09), mk_i(6'h08, 2, 1), mk_r(6'h00)};
        for (int n = 0; n < 500; n++) begin
            rpc  = 32'h0040_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
            ripc = 32'h0040_0000 | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
            rnpc = 32'h0040_1000 | ($urandom_range(0, 3) << 4);
            rir  = kinds[$urandom_range(0, 11)];
            m_predict(rpc, rpt, rppc);
            if ($urandom_range(0, 9) < 2) begin
                rpt  = 1'($urandom);
                rppc = rpt ? rnpc : rpc + 4;
            end
            step(0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15, rir, rpc, rpt, rppc,
                 rnpc, 32'h0040_2000 | ($urandom_range(0, 3) << 2), 1'($urandom), ripc,
                 $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
